instr_fetch_unit: RTL and testbench

//  Front-end fetch stage; sits directly upstream of the datapath. Owns the program counter and

---
 rtl/instr_fetch_unit_pkg.sv | 16 +
 rtl/ifu_fifo.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants and types for the instruction fetch unit
// Purpose: default widths, the reset fetch address, the instruction size and the
//          {instr, pc} entry type that is carried through the instruction FIFO.
// Ports:   none (package).
package instr_fetch_unit_pkg;

  localparam int IFU_XLEN = 32;
  localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [IFU_XLEN-1:0] instr;
    logic [IFU_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - parameterised synchronous FIFO with flush
// Purpose: DEPTH-entry FIFO (DEPTH a power of 2); head is read combinationally from
//          storage and forced to 0 while empty.
// Ports:   clk, reset (async, active-high); push/push_data write; pop removes head;
//          flush empties the FIFO and overrides push/pop; head, full, empty, count.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, credit-limited imem requests, instruction FIFO
// Purpose: issues word fetches, buffers returned words with their addresses and hands
//          them to the datapath; redirects flush buffered work and drop stale responses.
// Ports:   clk, reset (async, active-high); redirect_valid/redirect_pc; imem request
//          channel (imem_req_valid/ready/addr); imem response (imem_rsp_valid/data);
//          datapath channel (instr_valid/ready, instr, instr_pc).
// Option:  IFU_PERF_EN adds perf_fetched and perf_stall counters.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = IFU_XLEN,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     inflight;
  logic            req_fire;
  logic            rsp_keep;
  logic            pop;
  logic [XLEN-1:0] tag_pc;
  logic            instr_full;
  logic            instr_empty;
  logic            tag_full;
  logic            tag_empty;
  logic            unused_pc_bits;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  // low address bits of a redirect are forced to zero
  assign unused_pc_bits = ^redirect_pc[1:0];

  // every request reserves a FIFO slot until its word is consumed, so the
  // instruction FIFO can never overflow
  assign inflight       = {1'b0, occ} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // a response arriving with a redirect belongs to the old path and is discarded
  assign rsp_keep   = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign push_entry = '{instr: imem_rsp_data, pc: tag_pc};

  assign instr_valid = !instr_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  ifu_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .full      (instr_full),
    .empty     (instr_empty),
    .count     (occ)
  );

  // address of every issued request; never flushed because stale responses
  // still arrive and must retire their tag
  ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head      (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      // everything still outstanding after this cycle is stale
      drop     <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (!imem_req_valid && !redirect_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_keep && instr_full && !pop));
      assert (!(req_fire && tag_full));
      assert (!(imem_rsp_valid && tag_empty));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_one = 1'b1;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = '0;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .redirect_valid(w_zero), .redirect_pc(w_zero32),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_one),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_zero), .imem_rsp_data(w_zero32),
    .instr_valid(w_instr_valid), .instr_ready(w_zero),
    .instr(w_instr), .instr_pc(w_instr_pc)
`ifdef IFU_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a * 32'd7 + 32'h1000_0001;
  endfunction

  // controls applied at the next cycle
  logic        c_reset = 1'b1, c_redir = 1'b0, c_ready = 1'b1, c_reqrdy = 1'b1;
  logic [31:0] c_rpc = '0;
  int          lat = 1;
  int          cyc = 0;
  int          fires = 0;

  // memory model
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  // reference model: instruction queue, outstanding requests tagged stale or live
  logic [31:0] m_pc = '0;
  logic [31:0] m_fq_pc[$];
  logic [31:0] m_fq_d[$];
  logic [31:0] m_out_pc[$];
  bit          m_out_stale[$];
  logic [31:0] m_fetched = '0, m_stall = '0;

  // delivered stream as seen at the DUT
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_d[$];

  function automatic logic [31:0] dpc(input int i);
    return (dlv_pc.size() > i) ? dlv_pc[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dd(input int i);
    return (dlv_d.size() > i) ? dlv_d[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    logic        rsp_now, e_rv, e_iv, m_pop, keep, st;
    logic [31:0] e_addr, e_i, e_ipc, rpc;
    @(negedge clk);
    reset          = c_reset;
    redirect_valid = c_redir;
    redirect_pc    = c_rpc;
    instr_ready    = c_ready;
    imem_req_ready = c_reqrdy;
    if (c_reset) begin
      mq_addr.delete();
      mq_due.delete();
    end
    rsp_now        = !c_reset && (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mw(mq_addr[0]) : 32'h0;
    #1;
    if (c_reset) begin
      e_rv = 1'b0; e_addr = 32'h0; e_iv = 1'b0; e_i = 32'h0; e_ipc = 32'h0;
    end else begin
      e_rv   = !c_redir && ((m_fq_pc.size() + m_out_pc.size()) < 2);
      e_addr = m_pc;
      e_iv   = m_fq_pc.size() > 0;
      e_ipc  = e_iv ? m_fq_pc[0] : 32'h0;
      e_i    = e_iv ? m_fq_d[0] : 32'h0;
    end
    chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, e_rv});
    chk("imem_req_addr", imem_req_addr, e_addr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_iv});
    chk("instr", instr, e_i);
    chk("instr_pc", instr_pc, e_ipc);
`ifdef IFU_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
    if (rsp_now) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (!c_reset && imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + lat);
      fires++;
    end
    if (!c_reset && instr_valid && instr_ready) begin
      dlv_pc.push_back(instr_pc);
      dlv_d.push_back(instr);
    end
    if (c_reset) begin
      m_pc = 32'h0;
      m_fq_pc.delete(); m_fq_d.delete();
      m_out_pc.delete(); m_out_stale.delete();
      m_fetched = '0; m_stall = '0;
    end else begin
      m_pop = e_iv && c_ready;
      if (m_pop) m_fetched = m_fetched + 1;
      if (!e_rv && !c_redir) m_stall = m_stall + 1;
      keep = 1'b0;
      rpc  = '0;
      if (rsp_now && (m_out_pc.size() > 0)) begin
        rpc  = m_out_pc.pop_front();
        st   = m_out_stale.pop_front();
        keep = !st && !c_redir;
      end
      if (c_redir) begin
        m_fq_pc.delete(); m_fq_d.delete();
        foreach (m_out_stale[i]) m_out_stale[i] = 1'b1;
        m_pc = {c_rpc[31:2], 2'b00};
      end else begin
        if (m_pop) begin
          void'(m_fq_pc.pop_front());
          void'(m_fq_d.pop_front());
        end
        if (keep) begin
          m_fq_pc.push_back(rpc);
          m_fq_d.push_back(mw(rpc));
        end
        if (e_rv && c_reqrdy) begin
          m_out_pc.push_back(m_pc);
          m_out_stale.push_back(1'b0);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic restart(input int l, input logic rdy);
    c_reset = 1'b1; c_redir = 1'b0; c_ready = rdy; lat = l;
    repeat (2) tick();
    c_reset = 1'b0;
    dlv_pc.delete(); dlv_d.delete();
    fires = 0;
  endtask

  initial begin
    // reset and 1-cycle memory; wrap instance checked alongside
    repeat (2) tick();
    chk("rst_req_addr", imem_req_addr, 32'h0);
    c_reset = 1'b0;
    tick();
    chk("wrap_addr0", w_req_addr, 32'hFFFF_FFFC);
    chk("wrap_valid0", {31'b0, w_req_valid}, 32'h1);
    tick();
    chk("wrap_addr1", w_req_addr, 32'h0000_0000);
    chk("wrap_valid1", {31'b0, w_req_valid}, 32'h1);
    tick();
    chk("wrap_addr2", w_req_addr, 32'h0000_0004);
    chk("wrap_valid2", {31'b0, w_req_valid}, 32'h0);
    repeat (12) tick();
    chk("t1_pc0", dpc(0), 32'h0);
    chk("t1_pc1", dpc(1), 32'h4);
    chk("t1_pc2", dpc(2), 32'h8);
    chk("t1_pc3", dpc(3), 32'hC);
    chk("t1_d0", dd(0), 32'h1000_0001);
    chk("t1_d3", dd(3), 32'h1000_0055);

    // datapath stalled: exactly two requests, then release
    restart(1, 1'b0);
    repeat (10) tick();
    chk("t2_fires", fires, 2);
    chk("t2_req_stalled", {31'b0, imem_req_valid}, 32'h0);
    dlv_pc.delete(); dlv_d.delete();
    c_ready = 1'b1;
    repeat (8) tick();
    chk("t2_pc0", dpc(0), 32'h0);
    chk("t2_pc1", dpc(1), 32'h4);
    chk("t2_pc2", dpc(2), 32'h8);
    chk("t2_d1", dd(1), 32'h1000_001D);

    // two outstanding, redirect to 0x100
    restart(3, 1'b1);
    repeat (2) tick();
    c_redir = 1'b1; c_rpc = 32'h100;
    tick();
    c_redir = 1'b0;
    tick();
    chk("t3_addr", imem_req_addr, 32'h100);
    chk("t3_credit", {31'b0, imem_req_valid}, 32'h0);
    repeat (12) tick();
    chk("t3_pc0", dpc(0), 32'h100);
    chk("t3_d0", dd(0), 32'h1000_0701);

    // unaligned redirect coincident with pop and response
    restart(1, 1'b1);
    repeat (2) tick();
    c_redir = 1'b1; c_rpc = 32'h203;
    tick();
    chk("t4_pop_coinc", {31'b0, instr_valid}, 32'h1);
    chk("t4_rsp_coinc", {31'b0, imem_rsp_valid}, 32'h1);
    c_redir = 1'b0;
    tick();
    chk("t4_addr", imem_req_addr, 32'h200);
    repeat (8) tick();
    chk("t4_pc0", dpc(0), 32'h0);
    chk("t4_pc1", dpc(1), 32'h200);
    chk("t4_pc2", dpc(2), 32'h204);

    // reset with a buffered word and a request in flight
    restart(3, 1'b0);
    repeat (4) tick();
    c_reset = 1'b1;
    tick();
    chk("t6_ivalid", {31'b0, instr_valid}, 32'h0);
    chk("t6_rvalid", {31'b0, imem_req_valid}, 32'h0);
    chk("t6_addr", imem_req_addr, 32'h0);
    chk("t6_ipc", instr_pc, 32'h0);
    tick();
    c_reset = 1'b0; c_ready = 1'b1;
    repeat (10) tick();
    chk("t6_pc0", dpc(0), 32'h0);
    chk("t6_d0", dd(0), 32'h1000_0001);
    chk("t6_pc1", dpc(1), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
